trace_tx_sequencer: RTL
=======================

# trace_tx_sequencer

Sequences one measurement trace out of the single UART transmitter. On `start` it streams, in order, the 16-byte plaintext, 16-byte key, 16-byte ciphertext and `SAMPLES` on-chip-sensor bytes. For each byte it reads the byte store and drives the `uart_tx` valid/done handshake. After the last byte it holds an inter-trace gap, then pulses `done`. It sits between the AES/sensor capture buffers and `uart_tx`, and replaces the hand-coded send states in the main FSM.

## Interface
- `SAMPLES`, 2048: sensor bytes per trace; range 1..2^`ADDR_W`.
- `ADDR_W`, 11: read-address width.
- `GAP_CYCLES`, 4096: idle cycles after the last byte before `done`; 0 allowed.
- `clk` input 1: the single clock for all logic, including the UART clock domain.
- `rstn` input 1: asynchronous, active-low reset.
- `start` input 1: single-cycle request to send one trace.
- `sec_en` input 4: section enables, sampled on the accepted `start`. Bit 0 = PT, bit 1 = KEY, bit 2 = CT, bit 3 = SENSOR.
- `busy` output 1: high from the accepted `start` until `done`, inclusive.
- `done` output 1: one-cycle pulse at the end of the trace.
- `rd_sel` output 2: section being read. 0 = PT, 1 = KEY, 2 = CT, 3 = SENSOR.
- `rd_addr` output `ADDR_W`: byte index within the section.
- `rd_data` input 8: byte store output, valid exactly one cycle after `rd_sel`/`rd_addr` (registered read).
- `tx_dv` output 1: one-cycle transmit strobe to `uart_tx`.
- `tx_byte` output 8: byte to send; held stable until the next strobe.
- `tx_done` input 1: `uart_tx` completion pulse.
- `tx_count` output 16: bytes sent in the current trace.

## Operation
- Reset value of every output is 0: `busy`, `done`, `rd_sel`, `rd_addr`, `tx_dv`, `tx_byte`, `tx_count`. The FSM resets to IDLE.
- Section lengths: PT, KEY and CT are 16 each; SENSOR is `SAMPLES`. Section order is fixed at 0→1→2→3. Disabled sections are skipped entirely.
- States:
  - IDLE: on `start`, latch `sec_en`, clear `tx_count`, set `busy`, load `rd_sel` with the lowest enabled section and `rd_addr` = 0.
    - If no section is enabled, go to GAP.
    - Otherwise go to FETCH.
  - FETCH: wait one cycle while the read completes.
  - LOAD: `tx_byte` ← `rd_data`, `tx_dv` = 1 for this cycle only, `tx_count` += 1.
  - WAIT: `tx_dv` = 0; remain until `tx_done` = 1.
  - NEXT:
    - If `rd_addr` < length−1: increment `rd_addr` and go to FETCH.
    - Otherwise: set `rd_addr` = 0 and `rd_sel` = next enabled section, then go to FETCH.
    - If no enabled section remains, go to GAP.
  - GAP: count `GAP_CYCLES` cycles, then go to DONE.
  - DONE: `done` = 1, clear `busy`, return to IDLE.
- `rd_sel`/`rd_addr` stay at their last values in GAP and DONE. They change only in IDLE (on start) and NEXT.
- `tx_done` is ignored in every state except WAIT. A `tx_done` coincident with the strobe cycle is not counted.
- `start` is ignored while `busy` = 1; no queueing.
- `tx_count` is a 16-bit wrapping counter. It holds its value after `done` until the next accepted `start`.
- Deasserting `rstn` mid-trace aborts immediately: all outputs go to 0 and the FSM to IDLE. The byte in flight in `uart_tx` is not tracked.

## Timing
- `start` at cycle 0 → first `rd_addr` valid at cycle 1 → `tx_dv` at cycle 3 (FETCH at cycle 2, LOAD at cycle 3).
- Per-byte overhead outside the UART: `tx_done` at cycle t → NEXT at t+1 → FETCH at t+2 → next `tx_dv` at t+3.
- The last `tx_done` at cycle t → GAP entered at t+2 → `done` at t+2+`GAP_CYCLES`.
- With all sections disabled: `done` at cycle 2+`GAP_CYCLES` after `start`.
- `tx_byte` changes only in LOAD, so it is stable for the whole UART frame.

## Test plan
- Store pattern: PT[i]=i, KEY[i]=0x10+i, CT[i]=0x20+i, SENSOR[i]=i mod 256. `SAMPLES`=32, `sec_en`=0xF, UART model gives `tx_done` 10 cycles after `tx_dv` → 80 strobes in order 00..0F, 10..1F, 20..2F, 00..1F. `tx_count`=80. `done` exactly `GAP_CYCLES`+2 cycles after the last `tx_done`.
- `sec_en`=0b1010 → only the KEY then SENSOR bytes are sent. `rd_sel` never takes value 0 or 2. `tx_count`=16+`SAMPLES`.
- `sec_en`=0 → no `tx_dv`. `busy` is high for `GAP_CYCLES`+2 cycles, then a `done` pulse. `tx_count`=0.
- Second `start` and spurious `tx_done` pulses during FETCH/LOAD → byte stream and `tx_count` are unchanged versus the clean run. The second `start` is ignored.
- `rstn` pulsed low during SENSOR byte 5 → all outputs read 0 asynchronously. A subsequent `start` produces a complete, correct trace from PT[0].
- `SAMPLES`=1, `GAP_CYCLES`=0 → 49 bytes sent. `done` at 2 cycles after the last `tx_done`. No address overrun.

Source files
------------

// File: rtl/trace_tx_sequencer.sv
// trace_tx_sequencer: streams PT, KEY, CT and sensor bytes of one trace
// through uart_tx, then idles for an inter-trace gap and pulses done.
module trace_tx_sequencer #(
  parameter int SAMPLES    = 2048,
  parameter int ADDR_W     = 11,
  parameter int GAP_CYCLES = 4096
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic [3:0]        sec_en,
  output logic              busy,
  output logic              done,
  output logic [1:0]        rd_sel,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [7:0]        rd_data,
  output logic              tx_dv,
  output logic [7:0]        tx_byte,
  input  logic              tx_done,
  output logic [15:0]       tx_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_FETCH,
    S_LOAD,
    S_WAIT,
    S_NEXT,
    S_GAP,
    S_DONE
  } state_e;

  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0] GAP_LAST =
    GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [ADDR_W-1:0] SENS_LAST = ADDR_W'(SAMPLES - 1);
  localparam logic [ADDR_W-1:0] BLK_LAST  = ADDR_W'(15);
  // A zero-length gap goes straight to the done pulse
  localparam state_e END_ST = (GAP_CYCLES == 0) ? S_DONE : S_GAP;

  state_e            state_q, state_d;
  logic [3:0]        en_q, en_d;
  logic [1:0]        sel_q, sel_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [7:0]        byte_q, byte_d;
  logic [GW-1:0]     gap_q, gap_d;

  logic [3:0]        rest;
  logic [ADDR_W-1:0] last_addr;

  function automatic logic [1:0] lowest(input logic [3:0] v);
    lowest = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (v[i]) lowest = 2'(i);
    end
  endfunction

  // Enabled sections strictly after the current one
  assign rest      = en_q & (4'b1110 << sel_q);
  assign last_addr = (sel_q == 2'd3) ? SENS_LAST : BLK_LAST;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      en_q    <= '0;
      sel_q   <= '0;
      addr_q  <= '0;
      cnt_q   <= '0;
      byte_q  <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      en_q    <= en_d;
      sel_q   <= sel_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      byte_q  <= byte_d;
      gap_q   <= gap_d;
    end
  end

  always_comb begin
    state_d = state_q;
    en_d    = en_q;
    sel_d   = sel_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    byte_d  = byte_q;
    gap_d   = gap_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          en_d    = sec_en;
          cnt_d   = '0;
          sel_d   = lowest(sec_en);
          addr_d  = '0;
          state_d = S_ARM;
        end
      end
      S_ARM: begin
        gap_d   = '0;
        state_d = (en_q == 4'd0) ? END_ST : S_FETCH;
      end
      S_FETCH: state_d = S_LOAD;
      S_LOAD: begin
        byte_d  = rd_data;
        cnt_d   = cnt_q + 16'd1;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (tx_done) state_d = S_NEXT;
      end
      S_NEXT: begin
        gap_d = '0;
        if (addr_q != last_addr) begin
          addr_d  = addr_q + ADDR_W'(1);
          state_d = S_FETCH;
        end else if (|rest) begin
          addr_d  = '0;
          sel_d   = lowest(rest);
          state_d = S_FETCH;
        end else begin
          state_d = END_ST;
        end
      end
      S_GAP: begin
        if (gap_q == GAP_LAST) state_d = S_DONE;
        else gap_d = gap_q + GW'(1);
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // The strobe cycle presents the freshly read byte; it is held afterwards
  assign tx_dv    = (state_q == S_LOAD);
  assign tx_byte  = tx_dv ? rd_data : byte_q;
  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_DONE);
  assign rd_sel   = sel_q;
  assign rd_addr  = addr_q;
  assign tx_count = cnt_q;

endmodule
